bubble_page_loader: RTL and testbench
=====================================

// Module: bubble_page_loader
// PURPOSE
//  Upstream feeder of the bubble output buffer. Takes page bytes from the flash reader over a valid/ready byte
//  stream, serialises them, and issues one buffer write strobe per bit with a running bit address.
//  Drives nOUTBUFWCLKEN/OUTBUFWADDR/OUTBUFWDATA of the bubble interface, which splits even/odd addresses onto DOUT0/DOUT1.
//  Loads one bootloader or page image per command: base address and bit length are latched at start.
// PARAMETERS
//  ADDR_W     15  width of the bit address and bit-length fields; the address wraps modulo 2^ADDR_W
//  MSB_FIRST  1   1: byte bit 7 is written first; 0: bit 0 is written first
// PORTS
//  MCLK          in   1       48MHz system clock; all state changes on posedge
//  nRESET        in   1       asynchronous active-low reset
//  nLOADSTART    in   1       active-low, 1-cycle start command; sampled only in IDLE
//  LOADBASE      in   ADDR_W  first bit address; latched at start
//  LOADLEN       in   ADDR_W  number of bits to write (0..2^ADDR_W-1); latched at start
//  INDATA        in   8       page byte from the flash reader
//  INVALID       in   1       INDATA valid
//  INREADY       out  1       loader can accept a byte this cycle
//  nOUTBUFWCLKEN out  1       active-low buffer write strobe, one cycle per bit
//  OUTBUFWADDR   out  ADDR_W  buffer bit address for the current strobe
//  OUTBUFWDATA   out  1       bit value for the current strobe
//  LOADBUSY      out  1       high from the cycle after start through the DONE cycle
//  nLOADDONE     out  1       active-low 1-cycle completion pulse
// BEHAVIOUR
//  All outputs are registered. Reset values: INREADY=0, nOUTBUFWCLKEN=1, OUTBUFWADDR=0, OUTBUFWDATA=0,
//  LOADBUSY=0, nLOADDONE=1, state=IDLE, internal counters=0.
//  Reset asserted mid-load aborts at once. No further strobes are issued and the partial buffer contents are left as written.
//  FSM states: IDLE, WAIT_BYTE, SHIFT, DONE.
//   IDLE: when nLOADSTART=0 at posedge, latch addr<=LOADBASE and remain<=LOADLEN.
//         If LOADLEN==0 go to DONE, otherwise go to WAIT_BYTE.
//   WAIT_BYTE: INREADY=1. A byte is accepted at the posedge with INVALID&INREADY: load the shift reg, set bitcnt=0,
//         go to SHIFT. INREADY drops in the same edge. INVALID while not ready is ignored; the source holds the byte.
//   SHIFT: each cycle drive nOUTBUFWCLKEN=0, OUTBUFWADDR=addr, OUTBUFWDATA=current bit.
//         Then addr<=addr+1 (wraps 2^ADDR_W-1 -> 0), remain<=remain-1, bitcnt+1.
//         The last strobe of a byte is bitcnt==7 or remain==1.
//         After the last strobe: go to DONE if remain becomes 0, otherwise go to WAIT_BYTE.
//         nOUTBUFWCLKEN returns to 1 on any cycle with no strobe.
//   DONE: nLOADDONE=0 for exactly one cycle, LOADBUSY=1, then go to IDLE (LOADBUSY=0).
//  Latency: the first strobe appears 1 cycle after byte acceptance. Peak rate is 8 bits per 9 cycles.
//  Partial last byte: when LOADLEN is not a multiple of 8, the unused bits of the final byte are discarded.
//   No extra byte is requested.
//  nLOADSTART while not IDLE is ignored. LOADBASE/LOADLEN changes after the start edge have no effect.
//  Bit order is set by MSB_FIRST. The loader does not invert data; inversion for DOUT happens downstream.
//  Outputs change on posedge. The consumer samples the strobe on negedge MCLK, so the strobe is stable half a cycle.
// TESTING
//  start base=0, len=16; bytes 0xA5,0x3C -> 16 strobes, addr 0..15, data 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; one nLOADDONE pulse
//  start len=0 -> no strobes, INREADY never 1, nLOADDONE low 1 cycle after start, LOADBUSY high that cycle only
//  base=0x7FFE, len=4, byte 0xF0 -> addrs 0x7FFE,0x7FFF,0x0000,0x0001 with data 1,1,1,1; bits 3..0 discarded
//  INVALID held low 20 cycles in WAIT_BYTE -> INREADY stays 1, no strobes; byte 0x81 arrives -> strobes resume at the next addr
//  second nLOADSTART pulse during SHIFT -> ignored; addr/len unchanged; exactly len strobes total
//  nRESET low after 5 strobes -> all outputs at reset values next posedge; new start after release loads from the new LOADBASE

Source files
------------

// File: rtl/bubble_page_loader.sv
// rtl/bubble_page_loader.sv - serialises page bytes into per-bit bubble output buffer writes
module bubble_page_loader #(
    parameter int ADDR_W    = 15,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              MCLK,
    input  logic              nRESET,
    input  logic              nLOADSTART,
    input  logic [ADDR_W-1:0] LOADBASE,
    input  logic [ADDR_W-1:0] LOADLEN,
    input  logic [7:0]        INDATA,
    input  logic              INVALID,
    output logic              INREADY,
    output logic              nOUTBUFWCLKEN,
    output logic [ADDR_W-1:0] OUTBUFWADDR,
    output logic              OUTBUFWDATA,
    output logic              LOADBUSY,
    output logic              nLOADDONE
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BYTE = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic              ready_q, ready_d;
    logic              wclken_n_q, wclken_n_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_n_q, done_n_d;

    logic              cur_bit;
    logic              last_bit;

    assign cur_bit  = MSB_FIRST ? shift_q[7] : shift_q[0];
    assign last_bit = (bitcnt_q == 3'd7) || (remain_q == ONE);

    // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        wclken_n_d = 1'b1;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!nLOADSTART) begin
                    addr_d   = LOADBASE;
                    remain_d = LOADLEN;
                    state_d  = (LOADLEN == '0) ? ST_DONE : ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (INVALID && ready_q) begin
                    shift_d  = INDATA;
                    bitcnt_d = 3'd0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                wclken_n_d = 1'b0;
                waddr_d    = addr_q;
                wdata_d    = cur_bit;
                addr_d     = addr_q + ONE;
                remain_d   = remain_q - ONE;
                bitcnt_d   = bitcnt_q + 3'd1;
                shift_d    = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                if (last_bit) begin
                    // Leftover bits of a partial final byte are simply dropped here.
                    state_d = (remain_q == ONE) ? ST_DONE : ST_WAIT_BYTE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_WAIT_BYTE);
        busy_d   = (state_d != ST_IDLE);
        done_n_d = (state_d != ST_DONE);
    end

    // State, datapath and registered outputs; reset aborts any load immediately.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            ready_q    <= 1'b0;
            wclken_n_q <= 1'b1;
            waddr_q    <= '0;
            wdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            ready_q    <= ready_d;
            wclken_n_q <= wclken_n_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_n_q   <= done_n_d;
        end
    end

    assign INREADY       = ready_q;
    assign nOUTBUFWCLKEN = wclken_n_q;
    assign OUTBUFWADDR   = waddr_q;
    assign OUTBUFWDATA   = wdata_q;
    assign LOADBUSY      = busy_q;
    assign nLOADDONE     = done_n_q;

endmodule

// File: tb/tb_bubble_page_loader.sv
// tb/tb_bubble_page_loader.sv - self-checking bench for bubble_page_loader
module tb_bubble_page_loader;

    localparam int AW   = 15;
    localparam bit MSB  = 1'b1;
    localparam int MASK = (1 << AW) - 1;

    logic          MCLK;
    logic          nRESET;
    logic          nLOADSTART;
    logic [AW-1:0] LOADBASE;
    logic [AW-1:0] LOADLEN;
    logic [7:0]    INDATA;
    logic          INVALID;
    logic          INREADY;
    logic          nOUTBUFWCLKEN;
    logic [AW-1:0] OUTBUFWADDR;
    logic          OUTBUFWDATA;
    logic          LOADBUSY;
    logic          nLOADDONE;

    bubble_page_loader #(.ADDR_W(AW), .MSB_FIRST(MSB)) dut (
        .MCLK          (MCLK),
        .nRESET        (nRESET),
        .nLOADSTART    (nLOADSTART),
        .LOADBASE      (LOADBASE),
        .LOADLEN       (LOADLEN),
        .INDATA        (INDATA),
        .INVALID       (INVALID),
        .INREADY       (INREADY),
        .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
        .OUTBUFWADDR   (OUTBUFWADDR),
        .OUTBUFWDATA   (OUTBUFWDATA),
        .LOADBUSY      (LOADBUSY),
        .nLOADDONE     (nLOADDONE)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int errors = 0;
    int checks = 0;

    // Strobes and events as seen by the buffer, which samples on negedge.
    logic [AW-1:0] sa[$];
    logic          sd[$];
    int            done_cnt  = 0;
    int            ready_cnt = 0;

    always @(negedge MCLK) begin
        if (nRESET) begin
            if (!nOUTBUFWCLKEN) begin
                sa.push_back(OUTBUFWADDR);
                sd.push_back(OUTBUFWDATA);
            end
            if (!nLOADDONE) done_cnt++;
            if (INREADY) ready_cnt++;
        end
    end

    logic [7:0] src_q[$];
    int         sbase, dbase, rbase;
    int         cur_base, cur_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_bit(input int i);
        logic [7:0] b;
        int         pos;
        b   = src_q[i / 8];
        pos = MSB ? 7 - (i % 8) : (i % 8);
        return b[pos];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inready"}, INREADY, 0);
        check({tag, "_wclken"}, nOUTBUFWCLKEN, 1);
        check({tag, "_waddr"}, OUTBUFWADDR, 0);
        check({tag, "_wdata"}, OUTBUFWDATA, 0);
        check({tag, "_busy"}, LOADBUSY, 0);
        check({tag, "_done"}, nLOADDONE, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        INVALID = 1'b1;
        INDATA  = b;
        t = 0;
        while (INREADY !== 1'b1 && t < 400) begin
            @(negedge MCLK);
            t++;
        end
        check("handshake_timeout", t < 400, 1);
        @(negedge MCLK);
        INVALID = 1'b0;
        INDATA  = 8'($urandom);
    endtask

    task automatic start_load(input int base, input int len);
        sbase      = sa.size();
        dbase      = done_cnt;
        rbase      = ready_cnt;
        cur_base   = base & MASK;
        cur_len    = len;
        nLOADSTART = 1'b0;
        LOADBASE   = AW'(base);
        LOADLEN    = AW'(len);
        @(negedge MCLK);
        nLOADSTART = 1'b1;
        LOADBASE   = AW'($urandom);
        LOADLEN    = AW'($urandom);
        check("busy_after_start", LOADBUSY, 1);
        check("done_after_start", nLOADDONE, (len == 0) ? 0 : 1);
    endtask

    task automatic feed(input int gap_max, input bit poke);
        int nb;
        nb = (cur_len + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge MCLK);
            send_byte(src_q[k]);
            if (poke && k == 0) begin
                nLOADSTART = 1'b0;
                @(negedge MCLK);
                nLOADSTART = 1'b1;
            end
        end
    endtask

    task automatic compare_strobes(input int n);
        int ea;
        for (int i = 0; i < n; i++) begin
            ea = (cur_base + i) & MASK;
            check($sformatf("strobe%0d_addr_data", i), {sa[sbase + i], sd[sbase + i]}, {AW'(ea), model_bit(i)});
        end
    endtask

    task automatic finish_load();
        int t;
        int n;
        t = 0;
        while (done_cnt <= dbase && t < 600) begin
            @(negedge MCLK);
            t++;
        end
        check("done_timeout", t < 600, 1);
        repeat (3) @(negedge MCLK);
        check("done_pulse_cycles", done_cnt - dbase, 1);
        check("busy_idle", LOADBUSY, 0);
        check("inready_idle", INREADY, 0);
        check("wclken_idle", nOUTBUFWCLKEN, 1);
        n = sa.size() - sbase;
        check("strobe_count", n, cur_len);
        compare_strobes((n < cur_len) ? n : cur_len);
    endtask

    task automatic random_src(input int nbytes);
        src_q.delete();
        for (int k = 0; k < nbytes; k++) src_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [15:0] bits;
        int          t;
        int          nw;

        nRESET     = 1'b0;
        nLOADSTART = 1'b1;
        LOADBASE   = '0;
        LOADLEN    = '0;
        INDATA     = '0;
        INVALID    = 1'b0;
        repeat (3) @(negedge MCLK);
        check_reset_outputs("por");
        nRESET = 1'b1;
        @(negedge MCLK);

        // Two full bytes from address 0
        src_q = '{8'hA5, 8'h3C};
        start_load(0, 16);
        feed(0, 1'b0);
        finish_load();
        bits = '0;
        for (int i = 0; i < 16; i++) bits[15 - i] = sd[sbase + i];
        check("a53c_bit_sequence", bits, 16'hA53C);

        // Zero-length load
        src_q.delete();
        start_load(16'h0123, 0);
        @(negedge MCLK);
        check("len0_done_released", nLOADDONE, 1);
        check("len0_busy_released", LOADBUSY, 0);
        repeat (3) @(negedge MCLK);
        check("len0_no_inready", ready_cnt - rbase, 0);
        check("len0_no_strobes", sa.size() - sbase, 0);
        check("len0_one_done", done_cnt - dbase, 1);

        // Address wrap with a partial byte
        src_q = '{8'hF0};
        start_load(16'h7FFE, 4);
        feed(1, 1'b0);
        finish_load();

        // Source stalls 20 cycles while the loader waits
        src_q = '{8'($urandom), 8'h81};
        start_load(int'($urandom_range(MASK, 0)), 16);
        send_byte(src_q[0]);
        t = 0;
        while (INREADY !== 1'b1 && t < 50) begin
            @(negedge MCLK);
            t++;
        end
        check("stall_ready_timeout", t < 50, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge MCLK);
            check("stall_inready", INREADY, 1);
            check("stall_no_strobe", sa.size() - sbase, 8);
        end
        send_byte(src_q[1]);
        finish_load();

        // Extra start pulse while shifting is ignored
        random_src(3);
        start_load(int'($urandom_range(MASK, 0)), 20);
        feed(2, 1'b1);
        finish_load();

        // Random loads
        for (int r = 0; r < 6; r++) begin
            t = int'($urandom_range(40, 1));
            random_src((t + 7) / 8);
            start_load(int'($urandom_range(MASK, 0)), t);
            feed(3, 1'b0);
            finish_load();
        end

        // Reset in the middle of a load
        random_src(4);
        start_load(int'($urandom_range(MASK, 0)), 32);
        send_byte(src_q[0]);
        t = 0;
        while ((sa.size() - sbase) < 5 && t < 50) begin
            @(negedge MCLK);
            t++;
        end
        check("midreset_strobe_timeout", t < 50, 1);
        nRESET = 1'b0;
        #1;
        check_reset_outputs("midreset");
        nw = sa.size() - sbase;
        repeat (5) @(negedge MCLK);
        check_reset_outputs("midreset_held");
        check("midreset_no_more_strobes", sa.size() - sbase, nw);
        check("midreset_partial_count", (nw >= 5 && nw <= 6), 1);
        compare_strobes(nw);
        nRESET = 1'b1;
        @(negedge MCLK);
        random_src(2);
        start_load(int'($urandom_range(MASK, 0)), 12);
        feed(1, 1'b0);
        finish_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
